// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x32 register file: ALU/load arbitration,
// registered write port and RAW/WAW busy scoreboard.
//
// Ports:
//   sysclk, rst_n            clock, async active-low reset
//   alu_* / mem_*            valid/ready writeback requesters
//   issue_valid, issue_rd    destination of the issuing instruction
//   rs1, rs2                 sources of the issuing instruction
//   rs1_busy, rs2_busy,      combinational hazard outputs
//   stall, busy_mask
//   reg_write, write_reg,    registered reg-file write port
//   write_data
//
// Build option: define REGFILE_WB_RR_ARB_EN for round-robin arbitration
// between ALU and load; otherwise loads always beat the ALU.
module regfile_wb_scheduler #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                mem_win;
  logic                waw;
  logic                do_set;
  wb_t                 sel;

`ifdef REGFILE_WB_RR_ARB_EN
  // prio_mem=1: load wins the next contest; flips only on contests
  logic prio_mem;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      prio_mem <= 1'b1;
    end else if (alu_valid && mem_valid) begin
      prio_mem <= ~prio_mem;
    end
  end

  assign mem_win = mem_valid & (~alu_valid | prio_mem);
`else
  assign mem_win = mem_valid;
`endif

  assign mem_ready = mem_win;
  assign alu_ready = alu_valid & ~mem_win;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      mem_ready: sel = '{vld: 1'b1, rd: mem_rd, data: mem_data};
      alu_ready: sel = '{vld: 1'b1, rd: alu_rd, data: alu_data};
      default:   sel = '0;
    endcase
  end

  // x0 writes finish the handshake but never reach the port
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= sel.vld && (sel.rd != '0);
      if (sel.vld && (sel.rd != '0)) begin
        write_reg  <= sel.rd;
        write_data <= sel.data;
      end
    end
  end

  assign rs1_busy  = busy[rs1] & (rs1 != '0);
  assign rs2_busy  = busy[rs2] & (rs2 != '0);
  assign waw       = issue_valid & (issue_rd != '0) & busy[issue_rd];
  assign stall     = rs1_busy | rs2_busy | waw;
  assign do_set    = issue_valid & ~stall & (issue_rd != '0);
  assign busy_mask = busy;

  // Clear on reg-file landing; a same-edge set is the newer producer
  always_comb begin
    busy_nxt = busy;
    if (reg_write) busy_nxt[write_reg] = 1'b0;
    if (do_set)    busy_nxt[issue_rd]  = 1'b1;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios
// with literal expectations plus randomized traffic against a model.
module tb_regfile_wb_scheduler;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        rs1_busy, rs2_busy, stall;
  logic [31:0] busy_mask;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  always #5 sysclk = ~sysclk;

  regfile_wb_scheduler dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
    .busy_mask(busy_mask),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data)
  );

  int passed = 0;
  int total  = 0;

  // behavioural model state
  bit          mbusy [32];
  bit          m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  bit          m_last_mem_won;
  bit          alu_granted, mem_granted;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_rw = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
    m_last_mem_won = 1'b0;
  endtask

  function automatic bit m_mem_grant();
    if (!mem_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
`ifdef REGFILE_WB_RR_ARB_EN
    return !m_last_mem_won;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_src_busy(input logic [4:0] r);
    return (r != 0) && mbusy[r];
  endfunction

  function automatic bit m_stall();
    return m_src_busy(rs1) || m_src_busy(rs2) ||
           (issue_valid && issue_rd != 0 && mbusy[issue_rd]);
  endfunction

  task automatic compare_all();
    logic [31:0] mask;
    bit mg;
    for (int i = 0; i < 32; i++) mask[i] = mbusy[i];
    mg = m_mem_grant();
    chk("mem_ready", 64'(mem_ready), 64'(mg));
    chk("alu_ready", 64'(alu_ready), 64'(alu_valid && !mg));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_src_busy(rs1)));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_src_busy(rs2)));
    chk("stall", 64'(stall), 64'(m_stall()));
    chk("busy_mask", 64'(busy_mask), 64'(mask));
    chk("reg_write", 64'(reg_write), 64'(m_rw));
    chk("write_reg", 64'(write_reg), 64'(m_wreg));
    chk("write_data", 64'(write_data), 64'(m_wdata));
  endtask

  task automatic model_update();
    bit mg, ag, st;
    logic [4:0]  rd;
    logic [31:0] d;
    mg = m_mem_grant();
    ag = alu_valid && !mg;
    st = m_stall();
    rd = mg ? mem_rd : alu_rd;
    d  = mg ? mem_data : alu_data;
    if (m_rw) mbusy[m_wreg] = 1'b0;
    if (issue_valid && !st && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    if (alu_valid && mem_valid) m_last_mem_won = mg;
    m_rw = (mg || ag) && rd != 0;
    if (m_rw) begin
      m_wreg  = rd;
      m_wdata = d;
    end
    alu_granted = ag;
    mem_granted = mg;
  endtask

  // called at a negedge with inputs driven; returns at the next negedge
  task automatic step();
    #1 compare_all();
    @(posedge sysclk);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge sysclk);
  endtask

  initial begin
    bit [3:0] expm;
    rst_n = 1'b0;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; mem_data = 0;
    alu_granted = 0; mem_granted = 0;
    model_reset();
    @(negedge sysclk);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("lit_rst_reg_write", 64'(reg_write), 64'd0);
    chk("lit_rst_busy_mask", 64'(busy_mask), 64'd0);
    chk("lit_rst_write_data", 64'(write_data), 64'd0);

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("lit_alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 0;
    #1;
    chk("lit_alu_wr_en", 64'(reg_write), 64'd1);
    chk("lit_alu_wr_reg", 64'(write_reg), 64'd5);
    chk("lit_alu_wr_data", 64'(write_data), 64'hDEADBEEF);
    step();
    chk("lit_alu_wr_done", 64'(reg_write), 64'd0);

    // contention, each dropping after its grant
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
    #1;
    chk("lit_cont_mem_first", 64'(mem_ready), 64'd1);
    chk("lit_cont_alu_wait", 64'(alu_ready), 64'd0);
    step();
    mem_valid = 0;
    chk("lit_cont_wr4", 64'({write_reg, write_data}), 64'({5'd4, 32'h22}));
    step();
    alu_valid = 0;
    chk("lit_cont_wr3", 64'({write_reg, write_data}), 64'({5'd3, 32'h11}));
    step();

    // continuous contention
`ifdef REGFILE_WB_RR_ARB_EN
    expm = 4'b1010;
`else
    expm = 4'b1111;
`endif
    alu_valid = 1; mem_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lit_contest_grant", 64'(mem_ready), 64'(expm[k]));
      step();
    end
    alu_valid = 0; mem_valid = 0;

    // x0 suppression
    mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFFFFFF;
    #1 chk("lit_x0_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 0;
    chk("lit_x0_no_write", 64'(reg_write), 64'd0);
    chk("lit_x0_hold", 64'({write_reg, write_data}), 64'({5'd4, 32'h22}));
    step();

    // RAW stall
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    chk("lit_raw_busy7", 64'(busy_mask[7]), 64'd1);
    rs1 = 7;
    #1;
    chk("lit_raw_rs1_busy", 64'(rs1_busy), 64'd1);
    chk("lit_raw_stall", 64'(stall), 64'd1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    step();
    alu_valid = 0;
    chk("lit_raw_wr_cycle_en", 64'(reg_write), 64'd1);
    chk("lit_raw_wr_cycle_busy", 64'(rs1_busy), 64'd1);
    step();
    chk("lit_raw_cleared", 64'(rs1_busy), 64'd0);
    chk("lit_raw_no_stall", 64'(stall), 64'd0);
    rs1 = 0;

    // set/clear collision on x9
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 9;
    #1 chk("lit_coll_wr9", 64'({reg_write, write_reg}), 64'({1'b1, 5'd9}));
    step();
    chk("lit_coll_set_wins", 64'(busy_mask[9]), 64'd1);
    #1 chk("lit_waw_stall", 64'(stall), 64'd1);
    step();
    issue_valid = 1; issue_rd = 10; rs1 = 9;
    #1 chk("lit_raw_stall9", 64'(stall), 64'd1);
    step();
    issue_valid = 0; rs1 = 0;
    chk("lit_stall_no_set", 64'(busy_mask[10]), 64'd0);

    // reset mid-write
    alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
    issue_valid = 1; issue_rd = 5;
    step();
    chk("lit_pre_rst_busy5", 64'(busy_mask[5]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_midrst_reg_write", 64'(reg_write), 64'd0);
    chk("lit_midrst_busy", 64'(busy_mask), 64'd0);
    alu_valid = 0; issue_valid = 0;
    rst_n = 1'b1;
    model_reset();
    step();
    chk("lit_post_rst_no_wr", 64'(reg_write), 64'd0);
    chk("lit_post_rst_reg", 64'(write_reg), 64'd0);

    // randomized traffic
    alu_granted = 0; mem_granted = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || alu_granted) begin
        alu_valid = ($urandom_range(0, 99) < 55);
        alu_rd    = 5'($urandom_range(0, 9));
        alu_data  = $urandom;
      end
      if (!mem_valid || mem_granted) begin
        mem_valid = ($urandom_range(0, 99) < 45);
        mem_rd    = 5'($urandom_range(0, 9));
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = 5'($urandom_range(0, 9));
      rs1         = 5'($urandom_range(0, 9));
      rs2         = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences all writes into the 32x32 register file's single write port.
- Arbitrates between two writeback sources (ALU result, memory load) using valid/ready handshakes.
- Registers the winning write onto the reg-file port signals (reg_write, write_reg, write_data).
- Keeps a busy scoreboard of registers with writes in flight, so issue logic can stall on RAW/WAW hazards.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, write data width.
- NUM_REGS, 32, scoreboard depth; must equal 2**ADDR_W.

Ports:
- sysclk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  instruction issuing with a destination
- issue_rd  in  ADDR_W  destination of issuing instruction
- rs1  in  ADDR_W  source register 1 of issuing instruction
- rs2  in  ADDR_W  source register 2 of issuing instruction
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- stall  out  1  hold issue this cycle
- busy_mask  out  NUM_REGS  scoreboard state, bit i = register i pending
- reg_write  out  1  reg-file write enable (registered)
- write_reg  out  ADDR_W  reg-file write index (registered)
- write_data  out  DATA_W  reg-file write data (registered)

Behaviour:
- Reset (rst_n low, async): reg_write=0, write_reg=0, write_data=0, busy_mask=0, arbitration pointer=MEM. Combinational outputs follow from this state.
- Reset mid-operation: in-flight writes are discarded and the scoreboard is cleared. No write is asserted during reset or in the first cycle after it.
- Handshake:
  - alu_ready and mem_ready are combinational from the valids and arbitration state.
  - At most one is high per cycle.
  - A requester holds valid/rd/data stable until its ready is seen.
  - Transfer = valid & ready at the rising edge.
  - ready is never asserted without the matching valid.
- Arbitration (default fixed priority):
  - Both valid: MEM wins.
  - One valid: that one is granted immediately.
  - Throughput is one write per cycle.
- Latency: a transfer at edge N drives reg_write/write_reg/write_data in cycle N..N+1. The reg file captures it at edge N+1.
- Write with rd==0: handshake still completes. reg_write stays 0 the next cycle and write_reg/write_data hold their previous values (x0 is never written).
- No transfer: reg_write=0 next cycle.
- Scoreboard update:
  - Set: busy[issue_rd] set at the edge when issue_valid & !stall & issue_rd!=0.
  - Clear: busy[write_reg] cleared at the edge when reg_write=1, i.e. when the data lands in the reg file.
  - Set and clear of the same index at the same edge: set wins (newer producer).
  - A writeback to a non-busy register writes normally; the scoreboard is unchanged.
- Hazard outputs (combinational):
  - rs1_busy = busy[rs1] & (rs1!=0); rs2_busy likewise.
  - stall = rs1_busy | rs2_busy | (issue_valid & issue_rd!=0 & busy[issue_rd]) (WAW).
  - No forwarding: a source clears the cycle after the reg file has been written.

Optional Feature:
- Macro: REGFILE_WB_RR_ARB_EN.
- Defined: round-robin arbitration.
  - When both are valid, the requester not granted most recently wins.
  - The pointer updates only on contested grants.
  - After reset, MEM wins the first contest.
- Undefined: fixed MEM-over-ALU priority as above; no pointer flop is built.

Test Plan:
- Reset mid-write: alu_valid=1, alu_rd=5, issue rd=5 set, rst_n pulsed low between edges -> reg_write=0, busy_mask=0 immediately; no write to x5 after release.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF; following cycle reg_write=0.
- Contention, both valid for 4 cycles (ALU rd=3/0x11, MEM rd=4/0x22, each dropping after its grant):
  - Fixed: MEM granted first, then ALU; writes x4=0x22 then x3=0x11.
  - With REGFILE_WB_RR_ARB_EN and continuous requests: grants alternate MEM, ALU, MEM, ALU.
- x0 suppression: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1; reg_write stays 0; write_reg/write_data unchanged.
- RAW stall:
  - issue_valid=1, issue_rd=7 -> busy_mask[7]=1.
  - Then rs1=7 -> rs1_busy=1, stall=1.
  - ALU writes x7 -> rs1_busy stays 1 through the reg_write cycle, drops to 0 the cycle after.
- Set/clear collision: reg_write=1 with write_reg=9 at the same edge as issue_valid=1, issue_rd=9 (x9 not previously busy) -> busy_mask[9]=1 afterwards. A WAW issue to busy x9 -> stall=1 and no set.
